// File: rtl/iob_debounce_pkg.sv
// Shared definitions for the iob_debounce input conditioner.
package iob_debounce_pkg;

  // Filter state encoding: IDLE waits for a level change, QUAL qualifies it.
  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_t;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_QUAL = 1'b1;

endpackage : iob_debounce_pkg

// File: rtl/iob_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, with clock enable and
// synchronous reset so it follows the same hold/clear rules as the filter.
module iob_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic rst_i,
  input  logic bit_i,
  output logic bit_o
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; the last stage is the synchronized bit.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      chain <= {STAGES{RST_VAL}};
    end else if (cke_i) begin
      if (rst_i) begin
        chain <= {STAGES{RST_VAL}};
      end else begin
        chain <= {chain[STAGES-2:0], bit_i};
      end
    end
  end

  assign bit_o = chain[STAGES-1];

endmodule : iob_sync

// File: rtl/iob_debounce.sv
// Debouncer: synchronizes bit_i, then accepts a level change only after it has
// been stable for period_i enabled cycles (0 treated as 1).
// Optional macro IOB_DEBOUNCE_GLITCH_CNT_EN adds a saturating glitch_cnt_o that
// counts rejected changes.
module iob_debounce
  import iob_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RST_VAL     = 1'b0,
  parameter int unsigned GLITCH_W    = 8
) (
  input  logic             clk_i,
  input  logic             cke_i,
  input  logic             arst_n_i,
  input  logic             rst_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             bit_i,
  output logic             bit_o,
  output logic             busy_o
`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync;
  logic             abort;

  iob_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .bit_i    (bit_i),
    .bit_o    (sync)
  );

  // cnt stays below eff, so the increment never wraps.
  assign eff     = (period_i == '0) ? CNT_W'(1) : period_i;
  assign cnt_inc = cnt + CNT_W'(1);
  assign abort   = cke_i && !rst_i && (state == QUAL) && (sync == bit_o);

  // Qualification FSM with registered level and busy outputs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= IDLE;
      cnt    <= '0;
      bit_o  <= RST_VAL;
      busy_o <= 1'b0;
    end else if (cke_i) begin
      if (rst_i) begin
        state  <= IDLE;
        cnt    <= '0;
        bit_o  <= RST_VAL;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sync != bit_o) begin
              if (eff == CNT_W'(1)) begin
                bit_o <= sync;
              end else begin
                cnt    <= CNT_W'(1);
                state  <= QUAL;
                busy_o <= 1'b1;
              end
            end
          end
          QUAL: begin
            if (sync == bit_o) begin
              cnt    <= '0;
              state  <= IDLE;
              busy_o <= 1'b0;
            end else if (cnt_inc >= eff) begin
              bit_o  <= sync;
              cnt    <= '0;
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            cnt    <= '0;
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IOB_DEBOUNCE_GLITCH_CNT_EN
  // Saturating count of aborted qualifications; only reset clears it.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      glitch_cnt_o <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        glitch_cnt_o <= '0;
      end else if (abort && (glitch_cnt_o != '1)) begin
        glitch_cnt_o <= glitch_cnt_o + GLITCH_W'(1);
      end
    end
  end
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule : iob_debounce
